// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A/D channel opcodes and the burst beat-count helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package tl_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        ArithmeticData = 3'd2,
        LogicalData    = 3'd3,
        Get            = 3'd4,
        Intent         = 3'd5
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1,
        HintAck       = 3'd2
    } tl_d_op_e;

    // Wide enough for a 2^7-byte transfer on a 32-bit beat (32 beats).
    localparam int unsigned BeatCntW = 8;
    typedef logic [BeatCntW-1:0] beat_cnt_t;

    // Beats in a transfer of 2^size bytes on a bus with 2^lane_bits byte lanes.
    function automatic beat_cnt_t tl_beats(input logic [2:0] size, input logic [2:0] lane_bits);
        if (size <= lane_bits) begin
            return beat_cnt_t'(1);
        end
        return beat_cnt_t'(1) << (size - lane_bits);
    endfunction

endpackage

// File: rtl/muntjac_sram_1rw.sv
// Single-port synchronous SRAM model with per-byte write enables; drop-in point for a macro.
// Latency: read data on rdata_o one cycle after a read request; rdata_o holds until the next read.
// Backpressure: none (accepts one access per cycle).
// Ports: clk_i; req_i/we_i select read or write; addr_i word address; be_i byte enables;
//        wdata_i write data; rdata_o registered read data. Contents are never reset.
module muntjac_sram_1rw #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 8192
) (
    input  logic                       clk_i,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic [$clog2(Depth)-1:0]   addr_i,
    input  logic [DataWidth/8-1:0]     be_i,
    input  logic [DataWidth-1:0]       wdata_i,
    output logic [DataWidth-1:0]       rdata_o
);

    localparam int unsigned Bytes = DataWidth / 8;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                for (int b = 0; b < Bytes; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/muntjac_tl_sram_device.sv
// TL-UH device: serves Get/PutFullData/PutPartialData/Intent (bursts up to 2^MaxSize bytes) from a 1RW SRAM.
// Latency: Get accepted in cycle N -> first AccessAckData in N+2; last Put beat in N -> AccessAck in N+1.
// Backpressure: d_ready_i low freezes the read pipeline and holds all d_* fields; no new A until D completes.
// Ports: clk_i/rst_i (async, active-high); TileLink A channel a_* in, D channel d_* out.
// Optional feature: define MUNTJAC_TL_SRAM_BOUNDS_CHECK_EN to deny requests at or above MemBytes;
// otherwise upper address bits are ignored and the address wraps modulo MemBytes.
module muntjac_tl_sram_device
    import tl_pkg::*;
#(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned AddrWidth   = 56,
    parameter int unsigned SourceWidth = 4,
    parameter int unsigned SinkWidth   = 1,
    parameter int unsigned MemBytes    = 65536,
    parameter int unsigned MaxSize     = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     a_valid_i,
    output logic                     a_ready_o,
    input  logic [2:0]               a_opcode_i,
    input  logic [2:0]               a_param_i,
    input  logic [2:0]               a_size_i,
    input  logic [SourceWidth-1:0]   a_source_i,
    input  logic [AddrWidth-1:0]     a_address_i,
    input  logic [DataWidth/8-1:0]   a_mask_i,
    input  logic [DataWidth-1:0]     a_data_i,
    input  logic                     a_corrupt_i,

    output logic                     d_valid_o,
    input  logic                     d_ready_i,
    output logic [2:0]               d_opcode_o,
    output logic [2:0]               d_param_o,
    output logic [2:0]               d_size_o,
    output logic [SourceWidth-1:0]   d_source_o,
    output logic [SinkWidth-1:0]     d_sink_o,
    output logic                     d_denied_o,
    output logic                     d_corrupt_o,
    output logic [DataWidth-1:0]     d_data_o
);

    localparam int unsigned Bytes     = DataWidth / 8;
    localparam int unsigned LaneBitsI = $clog2(Bytes);
    localparam int unsigned Words     = MemBytes / Bytes;
    localparam int unsigned WordBits  = $clog2(Words);
    localparam int unsigned MemBits   = $clog2(MemBytes);
    localparam logic [2:0]  LaneBits  = 3'(LaneBitsI);
    localparam logic [2:0]  MaxSizeL  = 3'(MaxSize);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StAck,
        StErr
    } state_e;

    // Word address of beat k: the beat index lives in the low bits covered by
    // wmask and wraps inside the transfer; the bits above are fixed by the base.
    function automatic logic [WordBits-1:0] beat_addr(input logic [WordBits-1:0] base,
                                                      input logic [WordBits-1:0] wmask,
                                                      input beat_cnt_t           k);
        return (base & ~wmask) | ((base + WordBits'(k)) & wmask);
    endfunction

    state_e                state_q, state_d;
    logic [WordBits-1:0]   base_q, base_d;
    logic [WordBits-1:0]   wmask_q, wmask_d;
    beat_cnt_t             beats_q, beats_d;
    beat_cnt_t             cnt_q, cnt_d;        // A beats (write/drain) or D beats (read/err)
    beat_cnt_t             rd_cnt_q, rd_cnt_d;  // SRAM reads issued
    logic                  rd_pend_q, rd_pend_d; // SRAM rdata holds a beat not yet in the output reg
    logic                  drain_q, drain_d;
    logic                  wr_corrupt_q, wr_corrupt_d;

    logic                  d_valid_q, d_valid_d;
    tl_d_op_e              d_opcode_q, d_opcode_d;
    logic [2:0]            d_size_q, d_size_d;
    logic [SourceWidth-1:0] d_source_q, d_source_d;
    logic                  d_denied_q, d_denied_d;
    logic                  d_corrupt_q, d_corrupt_d;
    logic [DataWidth-1:0]  d_data_q, d_data_d;

    logic                  a_ready;
    logic                  sram_req, sram_we;
    logic [WordBits-1:0]   sram_addr;
    logic [DataWidth-1:0]  sram_rdata;

    // ---------------------------------------------------------------
    // A-channel request decode
    // ---------------------------------------------------------------
    logic                  a_is_get, a_is_put, a_is_intent, a_has_data, a_oob, a_bad;
    logic                  err_data;
    tl_d_op_e              err_op;
    beat_cnt_t             a_beats;
    logic [WordBits-1:0]   a_word;

    assign a_beats = tl_beats(a_size_i, LaneBits);
    assign a_word  = a_address_i[LaneBitsI +: WordBits];

    always_comb begin
        a_is_get    = 1'b0;
        a_is_put    = 1'b0;
        a_is_intent = 1'b0;
        a_has_data  = 1'b0;
        err_data    = 1'b0;
        err_op      = AccessAck;
        case (tl_a_op_e'(a_opcode_i))
            PutFullData, PutPartialData: begin
                a_is_put   = 1'b1;
                a_has_data = 1'b1;
            end
            ArithmeticData, LogicalData: begin
                a_has_data = 1'b1;
                err_data   = 1'b1;
                err_op     = AccessAckData;
            end
            Get: begin
                a_is_get = 1'b1;
                err_data = 1'b1;
                err_op   = AccessAckData;
            end
            Intent: begin
                a_is_intent = 1'b1;
                err_op      = HintAck;
            end
            default: begin
                err_op = AccessAck;
            end
        endcase
    end

`ifdef MUNTJAC_TL_SRAM_BOUNDS_CHECK_EN
    assign a_oob = |a_address_i[AddrWidth-1:MemBits];
`else
    assign a_oob = 1'b0;
`endif

    assign a_bad = a_oob | (a_size_i > MaxSizeL) | ~(a_is_get | a_is_put | a_is_intent);

    // ---------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wmask_d      = wmask_q;
        beats_d      = beats_q;
        cnt_d        = cnt_q;
        rd_cnt_d     = rd_cnt_q;
        rd_pend_d    = rd_pend_q;
        drain_d      = drain_q;
        wr_corrupt_d = wr_corrupt_q;
        // The output register empties on a D handshake unless reloaded below.
        d_valid_d    = d_valid_q & ~d_ready_i;
        d_opcode_d   = d_opcode_q;
        d_size_d     = d_size_q;
        d_source_d   = d_source_q;
        d_denied_d   = d_denied_q;
        d_corrupt_d  = d_corrupt_q;
        d_data_d     = d_data_q;
        a_ready      = 1'b0;
        sram_req     = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = beat_addr(base_q, wmask_q, rd_cnt_q);

        unique case (state_q)
            StIdle: begin
                a_ready = 1'b1;
                if (a_valid_i) begin
                    base_d       = a_word;
                    wmask_d      = WordBits'(a_beats - beat_cnt_t'(1));
                    beats_d      = a_beats;
                    cnt_d        = '0;
                    rd_cnt_d     = '0;
                    rd_pend_d    = 1'b0;
                    drain_d      = 1'b0;
                    wr_corrupt_d = 1'b0;
                    d_size_d     = a_size_i;
                    d_source_d   = a_source_i;
                    d_data_d     = '0;
                    d_denied_d   = 1'b0;
                    d_corrupt_d  = 1'b0;
                    if (a_bad) begin
                        state_d     = StErr;
                        d_opcode_d  = err_op;
                        d_denied_d  = 1'b1;
                        d_corrupt_d = err_data;
                        if (a_has_data && (a_beats != beat_cnt_t'(1))) begin
                            drain_d = 1'b1;
                            cnt_d   = beat_cnt_t'(1);
                        end else begin
                            d_valid_d = 1'b1;
                        end
                    end else if (a_is_get) begin
                        // First read goes out in the accept cycle so data lands in N+2.
                        sram_req   = 1'b1;
                        sram_addr  = a_word;
                        rd_cnt_d   = beat_cnt_t'(1);
                        rd_pend_d  = 1'b1;
                        d_opcode_d = AccessAckData;
                        state_d    = StRead;
                    end else if (a_is_put) begin
                        sram_req     = ~a_corrupt_i;
                        sram_we      = 1'b1;
                        sram_addr    = a_word;
                        wr_corrupt_d = a_corrupt_i;
                        d_opcode_d   = AccessAck;
                        if (a_beats == beat_cnt_t'(1)) begin
                            d_valid_d = 1'b1;
                            state_d   = StAck;
                        end else begin
                            cnt_d   = beat_cnt_t'(1);
                            state_d = StWrite;
                        end
                    end else begin
                        d_opcode_d = HintAck;
                        d_valid_d  = 1'b1;
                        state_d    = StAck;
                    end
                end
            end

            StRead: begin
                // Move the pending SRAM beat into the output register when it is free;
                // SRAM rdata holds while no new read is issued, so stalls lose nothing.
                if (rd_pend_q && (~d_valid_q | d_ready_i)) begin
                    d_valid_d = 1'b1;
                    d_data_d  = sram_rdata;
                    rd_pend_d = 1'b0;
                end
                if ((rd_cnt_q != beats_q) && (~rd_pend_q | ~d_valid_q | d_ready_i)) begin
                    sram_req  = 1'b1;
                    sram_addr = beat_addr(base_q, wmask_q, rd_cnt_q);
                    rd_cnt_d  = rd_cnt_q + beat_cnt_t'(1);
                    rd_pend_d = 1'b1;
                end
                if (d_valid_q && d_ready_i) begin
                    cnt_d = cnt_q + beat_cnt_t'(1);
                    if (cnt_q == beats_q - beat_cnt_t'(1)) begin
                        state_d = StIdle;
                    end
                end
            end

            StWrite: begin
                a_ready = 1'b1;
                if (a_valid_i) begin
                    sram_req     = ~a_corrupt_i;
                    sram_we      = 1'b1;
                    sram_addr    = beat_addr(base_q, wmask_q, cnt_q);
                    wr_corrupt_d = wr_corrupt_q | a_corrupt_i;
                    cnt_d        = cnt_q + beat_cnt_t'(1);
                    if (cnt_q == beats_q - beat_cnt_t'(1)) begin
                        d_valid_d = 1'b1;
                        state_d   = StAck;
                    end
                end
            end

            StAck: begin
                if (d_valid_q && d_ready_i) begin
                    state_d = StIdle;
                end
            end

            StErr: begin
                if (drain_q) begin
                    a_ready = 1'b1;
                    if (a_valid_i) begin
                        cnt_d = cnt_q + beat_cnt_t'(1);
                        if (cnt_q == beats_q - beat_cnt_t'(1)) begin
                            drain_d   = 1'b0;
                            cnt_d     = '0;
                            d_valid_d = 1'b1;
                        end
                    end
                end else if (d_valid_q && d_ready_i) begin
                    // Data-class errors return one zeroed, corrupt beat per transfer beat.
                    cnt_d = cnt_q + beat_cnt_t'(1);
                    if (!d_corrupt_q || (cnt_q == beats_q - beat_cnt_t'(1))) begin
                        state_d = StIdle;
                    end else begin
                        d_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            base_q       <= '0;
            wmask_q      <= '0;
            beats_q      <= '0;
            cnt_q        <= '0;
            rd_cnt_q     <= '0;
            rd_pend_q    <= 1'b0;
            drain_q      <= 1'b0;
            wr_corrupt_q <= 1'b0;
            d_valid_q    <= 1'b0;
            d_opcode_q   <= AccessAck;
            d_size_q     <= '0;
            d_source_q   <= '0;
            d_denied_q   <= 1'b0;
            d_corrupt_q  <= 1'b0;
            d_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            wmask_q      <= wmask_d;
            beats_q      <= beats_d;
            cnt_q        <= cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_pend_q    <= rd_pend_d;
            drain_q      <= drain_d;
            wr_corrupt_q <= wr_corrupt_d;
            d_valid_q    <= d_valid_d;
            d_opcode_q   <= d_opcode_d;
            d_size_q     <= d_size_d;
            d_source_q   <= d_source_d;
            d_denied_q   <= d_denied_d;
            d_corrupt_q  <= d_corrupt_d;
            d_data_q     <= d_data_d;
        end
    end

    muntjac_sram_1rw #(
        .DataWidth (DataWidth),
        .Depth     (Words)
    ) u_sram (
        .clk_i   (clk_i),
        .req_i   (sram_req),
        .we_i    (sram_we),
        .addr_i  (sram_addr),
        .be_i    (a_mask_i),
        .wdata_i (a_data_i),
        .rdata_o (sram_rdata)
    );

    assign a_ready_o   = a_ready & ~rst_i;
    assign d_valid_o   = d_valid_q;
    assign d_opcode_o  = d_opcode_q;
    assign d_param_o   = 3'd0;
    assign d_size_o    = d_size_q;
    assign d_source_o  = d_source_q;
    assign d_sink_o    = '0;
    assign d_denied_o  = d_denied_q;
    assign d_corrupt_o = d_corrupt_q;
    assign d_data_o    = d_data_q;

    // a_param_i carries no meaning for a UH device; sticky write-corrupt is status only.
    logic unused_sig;
    assign unused_sig = ^{a_param_i, a_address_i, wr_corrupt_q};

endmodule
